// File: rtl/diff_24bit_rr_sched.sv
// -----------------------------------------------------------------------------
// diff_24bit_rr_sched
//   Round-robin scheduler that shares a single 24-bit subtractor (diff_24bit)
//   among NUM_REQ requesters. Each cycle at most one requester is granted. Its
//   (a, b) pair is subtracted and stored in a one-entry result register. The
//   register holds the requester index and a borrow flag, and it drains
//   through a valid/ready port.
//
// Ports (diff_24bit_rr_sched)
//   clk         in   1            clock, all state on rising edge
//   rst         in   1            synchronous active-high reset
//   req_valid   in   NUM_REQ      requester i has an operand pair pending
//   req_ready   out  NUM_REQ      one-hot grant (combinational)
//   req_a       in   24*NUM_REQ   minuend of requester i at [24*i +: 24]
//   req_b       in   24*NUM_REQ   subtrahend of requester i at [24*i +: 24]
//   res_valid   out  1            result register is occupied
//   res_ready   in   1            consumer takes the result this cycle
//   res_diff    out  24           (a - b) mod 2^24
//   res_id      out  IDW          index of the requester that produced res_diff
//   res_borrow  out  1            1 iff a < b (unsigned)
//
// Ports (diff_24bit)
//   a_i, b_i    in   24           operands
//   diff_o      out  24           a_i - b_i, wrapping modulo 2^24
// -----------------------------------------------------------------------------

module diff_24bit (
  input  logic [23:0] a_i,
  input  logic [23:0] b_i,
  output logic [23:0] diff_o
);

  // Plain modular subtraction. The result wraps and never saturates.
  assign diff_o = a_i - b_i;

endmodule

module diff_24bit_rr_sched #(
  parameter int NUM_REQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [24*NUM_REQ-1:0]   req_a,
  input  logic [24*NUM_REQ-1:0]   req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [23:0]             res_diff,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic                    res_borrow
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic           res_valid_q, res_valid_d;
  logic [23:0]    res_diff_q, res_diff_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic           res_borrow_q, res_borrow_d;

  logic [IDW-1:0] winner;
  logic           any_valid;
  logic           accept_en;
  logic           grant;
  logic [23:0]    a_arr [NUM_REQ];
  logic [23:0]    b_arr [NUM_REQ];
  logic [23:0]    mux_a, mux_b, sub_diff;
  logic           mux_borrow;
  int             idx;

  // Split the flat operand buses into per-requester words so the winner can
  // select its pair with a simple array index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[24*i +: 24];
      b_arr[i] = req_b[24*i +: 24];
    end
  end

  // Round-robin search. It starts one slot past the last grant and wraps
  // around. The first valid slot found wins. Dropped requests are skipped.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!any_valid && req_valid[IDW'(idx)]) begin
        winner    = IDW'(idx);
        any_valid = 1'b1;
      end
    end
  end

  // A grant is possible only when the result register is empty or drains this
  // cycle. This is what holds every req_ready low during a stall.
  assign accept_en = !res_valid_q || res_ready;
  assign grant     = accept_en && any_valid;
  assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

  // The winner's operands feed the one shared subtractor. The borrow comes
  // from an unsigned compare of the same muxed pair.
  assign mux_a      = a_arr[winner];
  assign mux_b      = b_arr[winner];
  assign mux_borrow = mux_a < mux_b;

  diff_24bit u_diff (
    .a_i    (mux_a),
    .b_i    (mux_b),
    .diff_o (sub_diff)
  );

  // Next-state for the result register and the priority pointer. A transfer
  // loads a new result and moves the pointer. A drain with no transfer only
  // clears valid, so the data keeps its last value. Idle cycles and stalls
  // leave the pointer alone.
  always_comb begin
    last_grant_d = last_grant_q;
    res_valid_d  = res_valid_q;
    res_diff_d   = res_diff_q;
    res_id_d     = res_id_q;
    res_borrow_d = res_borrow_q;
    if (grant) begin
      res_valid_d  = 1'b1;
      res_diff_d   = sub_diff;
      res_id_d     = winner;
      res_borrow_d = mux_borrow;
      last_grant_d = winner;
    end else if (res_ready) begin
      res_valid_d  = 1'b0;
    end
  end

  // State registers. On reset the pointer goes to the last slot, which gives
  // requester 0 top priority. Any held result is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= IDW'(NUM_REQ - 1);
      res_valid_q  <= 1'b0;
      res_diff_q   <= '0;
      res_id_q     <= '0;
      res_borrow_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_diff_q   <= res_diff_d;
      res_id_q     <= res_id_d;
      res_borrow_q <= res_borrow_d;
    end
  end

  assign res_valid  = res_valid_q;
  assign res_diff   = res_diff_q;
  assign res_id     = res_id_q;
  assign res_borrow = res_borrow_q;

endmodule
